// File: rtl/hard_mem_1rw_arb_d512_w64_pkg.sv
// Shared types and constants for the two-requester SRAM arbiter.
// The state enum is kept here so the bench and debug tooling decode the same encoding.
package hard_mem_arb_pkg;

    localparam int num_req_gp = 2;

    typedef enum logic {
        e_init = 1'b0,
        e_run  = 1'b1
    } state_e;

endpackage

// File: rtl/hard_mem_1rw_arb_d512_w64_rr_arb2.sv
// Combinational two-way round-robin grant logic; the priority pointer lives in the caller.
// rr_i names the requester that wins when both request in the same cycle.
module hard_mem_rr_arb2
    import hard_mem_arb_pkg::*;
(
    input  logic [num_req_gp-1:0] req_i,
    input  logic                  rr_i,
    output logic [num_req_gp-1:0] grant_o,
    output logic                  grant_v_o
);

    assign grant_o[0] = req_i[0] & (~req_i[1] | ~rr_i);
    assign grant_o[1] = req_i[1] & (~req_i[0] |  rr_i);
    assign grant_v_o  = |req_i;

endmodule

// File: rtl/hard_mem_1rw_arb_d512_w64.sv
// Round-robin arbiter and sequencer that lets two requesters share one 1RW byte-masked SRAM.
// Define HARD_MEM_ARB_INIT_EN to zero the whole array after reset before accepting traffic.
module hard_mem_1rw_arb_d512_w64
    import hard_mem_arb_pkg::*;
#(
    parameter  int width_p       = 64,
    parameter  int els_p         = 512,
    localparam int addr_width_lp = $clog2(els_p),
    localparam int mask_width_lp = width_p >> 3
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic [num_req_gp-1:0]                 v_i,
    output logic [num_req_gp-1:0]                 ready_o,
    input  logic [num_req_gp-1:0]                 w_i,
    input  logic [num_req_gp*addr_width_lp-1:0]   addr_i,
    input  logic [num_req_gp*width_p-1:0]         data_i,
    input  logic [num_req_gp*mask_width_lp-1:0]   write_mask_i,
    output logic [num_req_gp-1:0]                 data_v_o,
    output logic [width_p-1:0]                    data_o,
    output logic                                  mem_v_o,
    output logic                                  mem_w_o,
    output logic [addr_width_lp-1:0]              mem_addr_o,
    output logic [width_p-1:0]                    mem_data_o,
    output logic [mask_width_lp-1:0]              mem_write_mask_o,
    input  logic [width_p-1:0]                    mem_data_i,
    output logic                                  dbg_state_o
);

    // Handshake: requester g transfers when v_i[g] & ready_o[g] in the same cycle; ready_o is
    // combinational and v_i may drop freely. Read data returns one cycle later on data_v_o[g]
    // with no backpressure.

    logic                     rr_r;
    logic                     rd_v_r;
    logic                     rd_id_r;
    logic                     r_mem_w;
    logic [addr_width_lp-1:0] r_mem_addr;
    logic [width_p-1:0]       r_mem_data;
    logic [mask_width_lp-1:0] r_mem_mask;

    state_e                   w_state;
    logic                     w_sweep;
    logic [addr_width_lp-1:0] w_sweep_addr;
    logic [num_req_gp-1:0]    w_req;
    logic [num_req_gp-1:0]    w_grant;
    logic                     w_grant_v;
    logic                     w_g;
    logic                     w_sel_w;
    logic [addr_width_lp-1:0] w_sel_addr;
    logic [width_p-1:0]       w_sel_data;
    logic [mask_width_lp-1:0] w_sel_mask;

`ifdef HARD_MEM_ARB_INIT_EN
    state_e                   state_r;
    state_e                   w_state_n;
    logic [addr_width_lp-1:0] sweep_cnt_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r     <= e_init;
            sweep_cnt_r <= '0;
        end else begin
            state_r <= w_state_n;
            if (state_r == e_init)
                sweep_cnt_r <= sweep_cnt_r + 1'b1;
        end
    end

    always_comb begin
        w_state_n = state_r;
        if (state_r == e_init && sweep_cnt_r == addr_width_lp'(els_p - 1))
            w_state_n = e_run;
    end

    assign w_state      = state_r;
    assign w_sweep      = (state_r == e_init) & ~reset_i;
    assign w_sweep_addr = sweep_cnt_r;
`else
    assign w_state      = e_run;
    assign w_sweep      = 1'b0;
    assign w_sweep_addr = '0;
`endif

    assign dbg_state_o = (w_state == e_run);
    assign w_req       = (w_state == e_run && !reset_i) ? v_i : '0;

    hard_mem_rr_arb2 u_arb (
        .req_i     (w_req),
        .rr_i      (rr_r),
        .grant_o   (w_grant),
        .grant_v_o (w_grant_v)
    );

    assign ready_o    = w_grant;
    assign w_g        = w_grant[1];
    assign w_sel_w    = w_i[w_g];
    assign w_sel_addr = w_g ? addr_i[2*addr_width_lp-1:addr_width_lp] : addr_i[addr_width_lp-1:0];
    assign w_sel_data = w_g ? data_i[2*width_p-1:width_p]             : data_i[width_p-1:0];
    assign w_sel_mask = w_g ? write_mask_i[2*mask_width_lp-1:mask_width_lp]
                            : write_mask_i[mask_width_lp-1:0];

    // Idle cycles replay the last access fields so the SRAM pins stay quiet.
    always_comb begin
        mem_v_o          = w_grant_v | w_sweep;
        mem_w_o          = r_mem_w;
        mem_addr_o       = r_mem_addr;
        mem_data_o       = r_mem_data;
        mem_write_mask_o = r_mem_mask;
        if (w_sweep) begin
            mem_w_o          = 1'b1;
            mem_addr_o       = w_sweep_addr;
            mem_data_o       = '0;
            mem_write_mask_o = '1;
        end else if (w_grant_v) begin
            mem_w_o          = w_sel_w;
            mem_addr_o       = w_sel_addr;
            mem_data_o       = w_sel_data;
            mem_write_mask_o = w_sel_mask;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_r       <= 1'b0;
            rd_v_r     <= 1'b0;
            rd_id_r    <= 1'b0;
            r_mem_w    <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_mem_mask <= '0;
        end else begin
            rd_v_r <= w_grant_v & ~w_sel_w;
            if (w_grant_v) begin
                rr_r    <= ~w_g;
                rd_id_r <= w_g;
            end
            if (mem_v_o) begin
                r_mem_w    <= mem_w_o;
                r_mem_addr <= mem_addr_o;
                r_mem_data <= mem_data_o;
                r_mem_mask <= mem_write_mask_o;
            end
        end
    end

    // Response is suppressed while reset is held so an in-flight read is dropped.
    assign data_v_o = (rd_v_r && !reset_i) ? (rd_id_r ? 2'b10 : 2'b01) : 2'b00;
    assign data_o   = mem_data_i;

endmodule

// File: tb/tb_hard_mem_1rw_arb_d512_w64.sv
// Bench for hard_mem_1rw_arb_d512_w64: behavioural SRAM, reference memory and fairness model.
// Honours HARD_MEM_ARB_INIT_EN so the same bench covers both builds.
module tb_hard_mem_1rw_arb_d512_w64;

    localparam int W   = 64;
    localparam int ELS = 512;
    localparam int AW  = 9;
    localparam int MW  = 8;
`ifdef HARD_MEM_ARB_INIT_EN
    localparam int INIT_CYC = ELS;
`else
    localparam int INIT_CYC = 0;
`endif

    logic            clk;
    logic            reset_i;
    logic [1:0]      v_i;
    logic [1:0]      ready_o;
    logic [1:0]      w_i;
    logic [2*AW-1:0] addr_i;
    logic [2*W-1:0]  data_i;
    logic [2*MW-1:0] write_mask_i;
    logic [1:0]      data_v_o;
    logic [W-1:0]    data_o;
    logic            mem_v_o;
    logic            mem_w_o;
    logic [AW-1:0]   mem_addr_o;
    logic [W-1:0]    mem_data_o;
    logic [MW-1:0]   mem_write_mask_o;
    logic [W-1:0]    mem_data_i;
    logic            dbg_state_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] sram    [ELS];
    logic [W-1:0] ref_mem [ELS];
    logic [W-1:0] exp_q[$];
    int           exp_id_q[$];

    hard_mem_1rw_arb_d512_w64 dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .v_i              (v_i),
        .ready_o          (ready_o),
        .w_i              (w_i),
        .addr_i           (addr_i),
        .data_i           (data_i),
        .write_mask_i     (write_mask_i),
        .data_v_o         (data_v_o),
        .data_o           (data_o),
        .mem_v_o          (mem_v_o),
        .mem_w_o          (mem_w_o),
        .mem_addr_o       (mem_addr_o),
        .mem_data_o       (mem_data_o),
        .mem_write_mask_o (mem_write_mask_o),
        .mem_data_i       (mem_data_i),
        .dbg_state_o      (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Single-port SRAM with one-cycle registered read.
    always @(posedge clk) begin
        if (mem_v_o) begin
            if (mem_w_o) begin
                for (int b = 0; b < MW; b++)
                    if (mem_write_mask_o[b]) sram[mem_addr_o][b*8 +: 8] = mem_data_o[b*8 +: 8];
            end else begin
                mem_data_i <= sram[mem_addr_o];
            end
        end
    end

    // ---------------- scoreboard ----------------
    int           last_g   = 1;
    int           init_left = INIT_CYC;
    logic         h_w      = 1'b0;
    logic [AW-1:0] h_addr  = '0;
    logic [W-1:0] h_data   = '0;
    logic [MW-1:0] h_mask  = '0;

    always @(negedge clk) begin
        int           g, sa, id;
        logic         gv, chk_d, rw;
        logic [1:0]   exp_dv, exp_rdy;
        logic [W-1:0] exp_d, rd;
        logic [AW-1:0] ra;
        logic [MW-1:0] rm;
        #2;
        if (reset_i) begin
            n_checks++;
            if (ready_o !== 2'b00 || mem_v_o !== 1'b0 || data_v_o !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_outputs: ready=%b mem_v=%b data_v=%b, required 00/0/00",
                         ready_o, mem_v_o, data_v_o);
            end
            exp_q.delete(); exp_id_q.delete();
            last_g = 1; init_left = INIT_CYC;
            h_w = 1'b0; h_addr = '0; h_data = '0; h_mask = '0;
        end else begin
            exp_dv = 2'b00; exp_d = '0; chk_d = 1'b0;
            if (exp_q.size() > 0) begin
                exp_d  = exp_q.pop_front();
                id     = exp_id_q.pop_front();
                exp_dv = (id == 1) ? 2'b10 : 2'b01;
                chk_d  = 1'b1;
            end
            n_checks++;
            if (data_v_o !== exp_dv) begin
                n_fail++;
                $display("FAIL sb_data_v: got %b, required %b", data_v_o, exp_dv);
            end
            if (chk_d) begin
                n_checks++;
                if (data_o !== exp_d) begin
                    n_fail++;
                    $display("FAIL sb_read_data: got %h, required %h", data_o, exp_d);
                end
            end
            if (init_left > 0) begin
                sa = ELS - init_left;
                n_checks++;
                if ({ready_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_write_mask_o} !==
                    {2'b00, 1'b1, 1'b1, AW'(sa), {W{1'b0}}, {MW{1'b1}}}) begin
                    n_fail++;
                    $display("FAIL sb_sweep: ready=%b v=%b w=%b addr=%0d data=%h mask=%h, required 00 1 1 %0d 0 ff",
                             ready_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_write_mask_o, sa);
                end
                ref_mem[sa] = '0;
                h_w = 1'b1; h_addr = AW'(sa); h_data = '0; h_mask = '1;
                init_left--;
            end else begin
                gv = 1'b1; g = 0;
                if (v_i == 2'b01)      g = 0;
                else if (v_i == 2'b10) g = 1;
                else if (v_i == 2'b11) g = (last_g == 0) ? 1 : 0;
                else                   gv = 1'b0;
                exp_rdy = gv ? ((g == 1) ? 2'b10 : 2'b01) : 2'b00;
                n_checks++;
                if (ready_o !== exp_rdy) begin
                    n_fail++;
                    $display("FAIL sb_grant: v_i=%b ready=%b, required %b", v_i, ready_o, exp_rdy);
                end
                if (gv) begin
                    rw = w_i[g];
                    ra = addr_i[g*AW +: AW];
                    rd = data_i[g*W +: W];
                    rm = write_mask_i[g*MW +: MW];
                    n_checks++;
                    if ({mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_write_mask_o} !==
                        {1'b1, rw, ra, rd, rm}) begin
                        n_fail++;
                        $display("FAIL sb_mem_route: v=%b w=%b addr=%0d data=%h mask=%h, required 1 %b %0d %h %h",
                                 mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_write_mask_o, rw, ra, rd, rm);
                    end
                    if (rw) begin
                        for (int b = 0; b < MW; b++)
                            if (rm[b]) ref_mem[ra][b*8 +: 8] = rd[b*8 +: 8];
                    end else begin
                        exp_q.push_back(ref_mem[ra]);
                        exp_id_q.push_back(g);
                    end
                    last_g = g;
                    h_w = rw; h_addr = ra; h_data = rd; h_mask = rm;
                end else begin
                    n_checks++;
                    if ({mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_write_mask_o} !==
                        {1'b0, h_w, h_addr, h_data, h_mask}) begin
                        n_fail++;
                        $display("FAIL sb_idle_hold: v=%b w=%b addr=%0d data=%h mask=%h, required 0 %b %0d %h %h",
                                 mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_write_mask_o,
                                 h_w, h_addr, h_data, h_mask);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_req(input int r, input logic v, input logic w, input logic [AW-1:0] a,
                             input logic [W-1:0] d, input logic [MW-1:0] m);
        v_i[r]                 = v;
        w_i[r]                 = w;
        addr_i[r*AW +: AW]     = a;
        data_i[r*W +: W]       = d;
        write_mask_i[r*MW +: MW] = m;
    endtask

    task automatic idle_all();
        drive_req(0, 1'b0, 1'b0, '0, '0, '0);
        drive_req(1, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        reset_i = 1'b1; idle_all();
        repeat (3) @(negedge clk);
        #3;
        n_checks++;
        if (ready_o !== 2'b00 || data_v_o !== 2'b00 || mem_v_o !== 1'b0) begin
            n_fail++;
            $display("FAIL test_reset_hold: ready=%b data_v=%b mem_v=%b, required 00 00 0",
                     ready_o, data_v_o, mem_v_o);
        end
        @(negedge clk);
        reset_i = 1'b0;
        #3;
        n_checks++;
        if (dbg_state_o !== ((INIT_CYC == 0) ? 1'b1 : 1'b0) || data_v_o !== 2'b00) begin
            n_fail++;
            $display("FAIL test_reset_state: run=%b data_v=%b, required run=%0d data_v=00",
                     dbg_state_o, data_v_o, (INIT_CYC == 0));
        end
    endtask

    task automatic test_init_sweep();
        int   cyc;
        logic done;
        @(negedge clk);
        reset_i = 1'b1; idle_all();
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        drive_req(0, 1'b1, 1'b0, 9'd1, '0, '0);
        drive_req(1, 1'b1, 1'b0, 9'd2, '0, '0);
        cyc = 0; done = 1'b0;
        while (!done && cyc < 700) begin
            #3;
            cyc++;
            if (ready_o !== 2'b00) done = 1'b1;
            else @(negedge clk);
        end
        n_checks++;
        if (!done || cyc != INIT_CYC + 1 || ready_o !== 2'b01) begin
            n_fail++;
            $display("FAIL test_init_first_grant: cycle=%0d ready=%b, required cycle=%0d ready=01",
                     cyc, ready_o, INIT_CYC + 1);
        end
        @(negedge clk);
        idle_all();
    endtask

    task automatic test_round_trip();
        @(negedge clk);
        drive_req(0, 1'b1, 1'b1, 9'd5, 64'hDEAD_BEEF_0123_4567, 8'hFF);
        #3;
        n_checks++;
        if (ready_o !== 2'b01) begin
            n_fail++; $display("FAIL test_rt_write_grant: ready=%b, required 01", ready_o);
        end
        @(negedge clk);
        drive_req(0, 1'b1, 1'b0, 9'd5, '0, '0);
        #3;
        n_checks++;
        if (ready_o !== 2'b01) begin
            n_fail++; $display("FAIL test_rt_read_grant: ready=%b, required 01", ready_o);
        end
        @(negedge clk);
        idle_all();
        #3;
        n_checks++;
        if (data_v_o !== 2'b01 || data_o !== 64'hDEAD_BEEF_0123_4567) begin
            n_fail++;
            $display("FAIL test_rt_response: data_v=%b data=%h, required 01 deadbeef01234567",
                     data_v_o, data_o);
        end
    endtask

    task automatic test_byte_mask();
        @(negedge clk);
        drive_req(1, 1'b1, 1'b1, 9'd9, '0, 8'hFF);
        @(negedge clk);
        drive_req(1, 1'b1, 1'b1, 9'd9, {W{1'b1}}, 8'h01);
        @(negedge clk);
        drive_req(1, 1'b1, 1'b0, 9'd9, '0, '0);
        @(negedge clk);
        idle_all();
        #3;
        n_checks++;
        if (data_v_o !== 2'b10 || data_o !== 64'h0000_0000_0000_00FF) begin
            n_fail++;
            $display("FAIL test_byte_mask: data_v=%b data=%h, required 10 00000000000000ff",
                     data_v_o, data_o);
        end
    endtask

    task automatic test_conflict();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive_req(0, 1'b1, 1'b0, AW'($urandom_range(0, 15)), '0, '0);
            drive_req(1, 1'b1, 1'b0, AW'($urandom_range(16, 31)), '0, '0);
            #3;
            n_checks++;
            if (ready_o !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL test_conflict_grant: step=%0d ready=%b, required %b",
                         i, ready_o, (i % 2 == 0) ? 2'b01 : 2'b10);
            end
            if (i > 0) begin
                n_checks++;
                if (data_v_o !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL test_conflict_tag: step=%0d data_v=%b, required %b",
                             i, data_v_o, (i % 2 == 0) ? 2'b10 : 2'b01);
                end
            end
        end
        @(negedge clk);
        idle_all();
        #3;
        n_checks++;
        if (data_v_o !== 2'b10) begin
            n_fail++; $display("FAIL test_conflict_last_tag: data_v=%b, required 10", data_v_o);
        end
    endtask

    task automatic test_random(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            for (int r = 0; r < 2; r++)
                drive_req(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          AW'($urandom_range(0, 15)), {$urandom, $urandom},
                          MW'($urandom_range(0, 255)));
        end
        @(negedge clk);
        idle_all();
    endtask

    task automatic test_idle();
        @(negedge clk);
        drive_req(0, 1'b1, 1'b0, 9'd77, '0, '0);
        @(negedge clk);
        idle_all();
        for (int i = 0; i < 10; i++) begin
            #3;
            n_checks++;
            if (mem_v_o !== 1'b0 || mem_addr_o !== 9'd77) begin
                n_fail++;
                $display("FAIL test_idle: cycle=%0d mem_v=%b addr=%0d, required 0 77",
                         i, mem_v_o, mem_addr_o);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        drive_req(0, 1'b1, 1'b0, 9'd5, '0, '0);
        #3;
        n_checks++;
        if (ready_o !== 2'b01) begin
            n_fail++; $display("FAIL test_rmr_grant: ready=%b, required 01", ready_o);
        end
        @(negedge clk);
        idle_all(); reset_i = 1'b1;
        #3;
        n_checks++;
        if (data_v_o !== 2'b00) begin
            n_fail++; $display("FAIL test_rmr_drop: data_v=%b, required 00", data_v_o);
        end
        @(negedge clk);
        reset_i = 1'b0;
        #3;
        n_checks++;
        if (data_v_o !== 2'b00) begin
            n_fail++; $display("FAIL test_rmr_after: data_v=%b, required 00", data_v_o);
        end
`ifdef HARD_MEM_ARB_INIT_EN
        n_checks++;
        if (mem_v_o !== 1'b1 || mem_w_o !== 1'b1 || mem_addr_o !== 9'd0 || ready_o !== 2'b00) begin
            n_fail++;
            $display("FAIL test_rmr_sweep_restart: v=%b w=%b addr=%0d ready=%b, required 1 1 0 00",
                     mem_v_o, mem_w_o, mem_addr_o, ready_o);
        end
        repeat (ELS) @(negedge clk);
`endif
        test_random(40);
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        reset_i = 1'b1;
        v_i = '0; w_i = '0; addr_i = '0; data_i = '0; write_mask_i = '0;
        mem_data_i = '0;
        for (int i = 0; i < ELS; i++) begin
            sram[i]    = {$urandom, $urandom};
            ref_mem[i] = sram[i];
        end
        test_reset();
        test_init_sweep();
        test_round_trip();
        test_byte_mask();
        test_conflict();
        test_random(400);
        test_idle();
        test_reset_mid_read();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
